// File: rtl/rf_iw_pingpong_mlane.sv
// Double-buffered operand register file with hardware-managed bank ownership.
// One write port fills the EMPTY bank owned by the loader; LANES synchronous
// read ports drain the FULL bank owned by the PE side. Banks swap ownership on
// w_last (fill complete) and r_release (reader done).
module rf_iw_pingpong_mlane #(
  parameter int unsigned DATA_BITWIDTH = 8,
  parameter int unsigned ADDR_BITWIDTH = 4,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned LANES         = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             w_en,
  input  logic [ADDR_BITWIDTH-1:0]         w_addr,
  input  logic [DATA_BITWIDTH-1:0]         w_data,
  input  logic                             w_last,
  output logic                             w_ready,
  output logic                             w_drop,
  output logic                             r_valid,
  input  logic [LANES-1:0]                 r_en,
  input  logic [LANES*ADDR_BITWIDTH-1:0]   r_addr,
  output logic [LANES*DATA_BITWIDTH-1:0]   r_data,
  output logic [LANES-1:0]                 r_data_vld,
  input  logic                             r_release,
  output logic                             wbank,
  output logic                             rbank
);

  localparam int unsigned DW = DATA_BITWIDTH;
  localparam int unsigned AW = ADDR_BITWIDTH;
  // Address bound with one spare bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  // Bank ownership: 1 = FULL (reader owns), 0 = EMPTY (writer owns).
  logic [1:0]          full_q, full_d;
  logic                wbank_q, wbank_d;
  logic                rbank_q, rbank_d;
  logic                w_drop_q, w_drop_d;
  logic [LANES*DW-1:0] r_data_q, r_data_d;
  logic [LANES-1:0]    r_data_vld_q, r_data_vld_d;

  // Storage is intentionally not reset; stale data is fenced off by full_q.
  logic [DW-1:0]       mem_q [2][DEPTH];

  logic                w_addr_ok;
  logic                w_accept;
  logic                rel_take;

  assign w_ready    = ~full_q[wbank_q];
  assign r_valid    = full_q[rbank_q];
  assign w_addr_ok  = ({1'b0, w_addr} < DEPTH_LIM);
  assign w_accept   = w_en & w_ready & w_addr_ok;
  assign rel_take   = r_release & r_valid;

  assign w_drop     = w_drop_q;
  assign r_data     = r_data_q;
  assign r_data_vld = r_data_vld_q;
  assign wbank      = wbank_q;
  assign rbank      = rbank_q;

  // Ownership next state: fill completion and release always hit different banks.
  always_comb begin
    full_d   = full_q;
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    w_drop_d = w_en & ~w_accept;
    if (w_accept && w_last) begin
      full_d[wbank_q] = 1'b1;
      wbank_d         = ~wbank_q;
    end
    if (rel_take) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
    end
  end

  // Per-lane read path: sample the reader-owned bank, out-of-range returns zero.
  always_comb begin
    r_data_d     = r_data_q;
    r_data_vld_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (r_en[i] && r_valid) begin
        r_data_vld_d[i] = 1'b1;
        if ({1'b0, r_addr[i*AW +: AW]} < DEPTH_LIM) begin
          r_data_d[i*DW +: DW] = mem_q[rbank_q][r_addr[i*AW +: AW]];
        end else begin
          r_data_d[i*DW +: DW] = '0;
        end
      end
    end
  end

  // Control and read-output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q       <= 2'b00;
      wbank_q      <= 1'b0;
      rbank_q      <= 1'b0;
      w_drop_q     <= 1'b0;
      r_data_q     <= '0;
      r_data_vld_q <= '0;
    end else begin
      full_q       <= full_d;
      wbank_q      <= wbank_d;
      rbank_q      <= rbank_d;
      w_drop_q     <= w_drop_d;
      r_data_q     <= r_data_d;
      r_data_vld_q <= r_data_vld_d;
    end
  end

  // Write port into the writer-owned bank.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      mem_q[wbank_q][w_addr] <= w_data;
    end
  end

endmodule

// File: tb/tb_rf_iw_pingpong_mlane.sv
// Scoreboard bench for rf_iw_pingpong_mlane: three builds (default, DEPTH=12,
// LANES=4). Stimulus pushes expected read responses; a monitor pops them
// whenever a DUT raises r_data_vld.
module tb_rf_iw_pingpong_mlane;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  exp_t exp_m[$];
  exp_t exp_d[$];
  exp_t exp_f[$];

  // Default build: DEPTH 16, LANES 2
  logic        m_w_en, m_w_last, m_r_release;
  logic [3:0]  m_w_addr;
  logic [7:0]  m_w_data;
  logic [1:0]  m_r_en;
  logic [7:0]  m_r_addr;
  logic [15:0] m_r_data;
  logic [1:0]  m_r_data_vld;
  logic        m_w_ready, m_w_drop, m_r_valid, m_wbank, m_rbank;

  // DEPTH 12 build
  logic        d_w_en, d_w_last, d_r_release;
  logic [3:0]  d_w_addr;
  logic [7:0]  d_w_data;
  logic [1:0]  d_r_en;
  logic [7:0]  d_r_addr;
  logic [15:0] d_r_data;
  logic [1:0]  d_r_data_vld;
  logic        d_w_ready, d_w_drop, d_r_valid, d_wbank, d_rbank;

  // LANES 4 build
  logic        f_w_en, f_w_last, f_r_release;
  logic [3:0]  f_w_addr;
  logic [7:0]  f_w_data;
  logic [3:0]  f_r_en;
  logic [15:0] f_r_addr;
  logic [31:0] f_r_data;
  logic [3:0]  f_r_data_vld;
  logic        f_w_ready, f_w_drop, f_r_valid, f_wbank, f_rbank;

  rf_iw_pingpong_mlane #(.DATA_BITWIDTH(8), .ADDR_BITWIDTH(4), .DEPTH(16), .LANES(2)) dut_m (
    .clk(clk), .reset(reset),
    .w_en(m_w_en), .w_addr(m_w_addr), .w_data(m_w_data), .w_last(m_w_last),
    .w_ready(m_w_ready), .w_drop(m_w_drop), .r_valid(m_r_valid),
    .r_en(m_r_en), .r_addr(m_r_addr), .r_data(m_r_data), .r_data_vld(m_r_data_vld),
    .r_release(m_r_release), .wbank(m_wbank), .rbank(m_rbank)
  );

  rf_iw_pingpong_mlane #(.DATA_BITWIDTH(8), .ADDR_BITWIDTH(4), .DEPTH(12), .LANES(2)) dut_d (
    .clk(clk), .reset(reset),
    .w_en(d_w_en), .w_addr(d_w_addr), .w_data(d_w_data), .w_last(d_w_last),
    .w_ready(d_w_ready), .w_drop(d_w_drop), .r_valid(d_r_valid),
    .r_en(d_r_en), .r_addr(d_r_addr), .r_data(d_r_data), .r_data_vld(d_r_data_vld),
    .r_release(d_r_release), .wbank(d_wbank), .rbank(d_rbank)
  );

  rf_iw_pingpong_mlane #(.DATA_BITWIDTH(8), .ADDR_BITWIDTH(4), .DEPTH(16), .LANES(4)) dut_f (
    .clk(clk), .reset(reset),
    .w_en(f_w_en), .w_addr(f_w_addr), .w_data(f_w_data), .w_last(f_w_last),
    .w_ready(f_w_ready), .w_drop(f_w_drop), .r_valid(f_r_valid),
    .r_en(f_r_en), .r_addr(f_r_addr), .r_data(f_r_data), .r_data_vld(f_r_data_vld),
    .r_release(f_r_release), .wbank(f_wbank), .rbank(f_rbank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one expected entry per cycle in which a DUT returns data.
  exp_t em, ed, ef;
  always @(posedge clk) begin
    #1;
    if (m_r_data_vld != 2'b00) begin
      if (exp_m.size() == 0) chk("m_unexpected_vld", 64'(m_r_data_vld), 64'd0);
      else begin
        em = exp_m.pop_front();
        chk("m_rd_vld", 64'(m_r_data_vld), 64'(em.mask[1:0]));
        chk("m_rd_data", 64'(m_r_data), 64'(em.data[15:0]));
      end
    end
    if (d_r_data_vld != 2'b00) begin
      if (exp_d.size() == 0) chk("d_unexpected_vld", 64'(d_r_data_vld), 64'd0);
      else begin
        ed = exp_d.pop_front();
        chk("d_rd_vld", 64'(d_r_data_vld), 64'(ed.mask[1:0]));
        chk("d_rd_data", 64'(d_r_data), 64'(ed.data[15:0]));
      end
    end
    if (f_r_data_vld != 4'b0000) begin
      if (exp_f.size() == 0) chk("f_unexpected_vld", 64'(f_r_data_vld), 64'd0);
      else begin
        ef = exp_f.pop_front();
        chk("f_rd_vld", 64'(f_r_data_vld), 64'(ef.mask));
        chk("f_rd_data", 64'(f_r_data), 64'(ef.data));
      end
    end
  end

  task automatic m_write(input logic [3:0] a, input logic [7:0] d, input logic last, input logic rel);
    m_w_en = 1'b1; m_w_addr = a; m_w_data = d; m_w_last = last; m_r_release = rel;
    tick();
    m_w_en = 1'b0; m_w_last = 1'b0; m_r_release = 1'b0;
  endtask

  task automatic m_read(input logic [3:0] a0, input logic [3:0] a1, input logic [15:0] expd);
    m_r_en = 2'b11; m_r_addr = {a1, a0};
    exp_m.push_back({4'b0011, 32'(expd)});
    tick();
    m_r_en = 2'b00;
  endtask

  task automatic d_write(input logic [3:0] a, input logic [7:0] d, input logic last);
    d_w_en = 1'b1; d_w_addr = a; d_w_data = d; d_w_last = last;
    tick();
    d_w_en = 1'b0; d_w_last = 1'b0;
  endtask

  task automatic d_read(input logic [3:0] a0, input logic [3:0] a1, input logic [15:0] expd);
    d_r_en = 2'b11; d_r_addr = {a1, a0};
    exp_d.push_back({4'b0011, 32'(expd)});
    tick();
    d_r_en = 2'b00;
  endtask

  task automatic f_read(input logic [15:0] addrs, input logic [31:0] expd);
    f_r_en = 4'b1111; f_r_addr = addrs;
    exp_f.push_back({4'b1111, expd});
    tick();
    f_r_en = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    m_w_en = 0; m_w_last = 0; m_r_release = 0; m_w_addr = 0; m_w_data = 0; m_r_en = 0; m_r_addr = 0;
    d_w_en = 0; d_w_last = 0; d_r_release = 0; d_w_addr = 0; d_w_data = 0; d_r_en = 0; d_r_addr = 0;
    f_w_en = 0; f_w_last = 0; f_r_release = 0; f_w_addr = 0; f_w_data = 0; f_r_en = 0; f_r_addr = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_r_data", 64'(m_r_data), 64'd0);
    chk("rst_r_vld", 64'(m_r_data_vld), 64'd0);
    chk("rst_w_drop", 64'(m_w_drop), 64'd0);
    chk("rst_wbank", 64'(m_wbank), 64'd0);
    chk("rst_rbank", 64'(m_rbank), 64'd0);
    chk("rst_r_valid", 64'(m_r_valid), 64'd0);
    chk("rst_w_ready", 64'(m_w_ready), 64'd1);
    reset = 1'b1;
    tick();

    // Fill B0 with addr+1
    for (int a = 0; a < 16; a++) m_write(4'(a), 8'(a + 1), (a == 15), 1'b0);
    chk("fill0_wbank", 64'(m_wbank), 64'd1);
    chk("fill0_rbank", 64'(m_rbank), 64'd0);
    chk("fill0_r_valid", 64'(m_r_valid), 64'd1);
    chk("fill0_w_ready", 64'(m_w_ready), 64'd1);
    chk("fill0_w_drop", 64'(m_w_drop), 64'd0);
    m_read(4'd5, 4'd15, 16'h1006);

    // Fill B1 with 0xA0+addr; release coincides with w_last, reads that cycle use B0
    for (int a = 0; a < 15; a++) m_write(4'(a), 8'(160 + a), 1'b0, 1'b0);
    chk("pp_r_valid_before", 64'(m_r_valid), 64'd1);
    m_r_en = 2'b11; m_r_addr = {4'd4, 4'd3};
    exp_m.push_back({4'b0011, 32'h0000_0504});
    m_write(4'd15, 8'hAF, 1'b1, 1'b1);
    m_r_en = 2'b00;
    chk("pp_rbank", 64'(m_rbank), 64'd1);
    chk("pp_wbank", 64'(m_wbank), 64'd0);
    chk("pp_r_valid", 64'(m_r_valid), 64'd1);
    chk("pp_w_ready", 64'(m_w_ready), 64'd1);
    m_read(4'd0, 4'd15, 16'hAFA0);
    m_read(4'd7, 4'd7, 16'hA7A7);

    // Refill B0 with 0x50+addr without release: both banks FULL
    for (int a = 0; a < 16; a++) m_write(4'(a), 8'(80 + a), (a == 15), 1'b0);
    chk("both_full_w_ready", 64'(m_w_ready), 64'd0);
    chk("both_full_wbank", 64'(m_wbank), 64'd1);
    m_write(4'd0, 8'hFF, 1'b1, 1'b0);
    chk("drop_pulse", 64'(m_w_drop), 64'd1);
    chk("drop_wbank", 64'(m_wbank), 64'd1);
    chk("drop_w_ready", 64'(m_w_ready), 64'd0);
    tick();
    chk("drop_pulse_end", 64'(m_w_drop), 64'd0);
    m_read(4'd0, 4'd15, 16'hAFA0);
    m_r_release = 1'b1; tick(); m_r_release = 1'b0;
    chk("rel1_rbank", 64'(m_rbank), 64'd0);
    chk("rel1_r_valid", 64'(m_r_valid), 64'd1);
    chk("rel1_w_ready", 64'(m_w_ready), 64'd1);
    m_read(4'd0, 4'd9, 16'h5950);
    m_r_release = 1'b1; tick(); m_r_release = 1'b0;
    chk("rel2_rbank", 64'(m_rbank), 64'd1);
    chk("rel2_r_valid", 64'(m_r_valid), 64'd0);

    // Release and reads while nothing is readable are ignored
    m_r_release = 1'b1; m_r_en = 2'b11; m_r_addr = 8'h21;
    tick();
    m_r_release = 1'b0; m_r_en = 2'b00;
    chk("ign_rbank", 64'(m_rbank), 64'd1);
    chk("ign_wbank", 64'(m_wbank), 64'd1);
    chk("ign_r_valid", 64'(m_r_valid), 64'd0);
    chk("ign_vld", 64'(m_r_data_vld), 64'd0);
    chk("ign_hold", 64'(m_r_data), 64'h5950);

    // DEPTH 12: out-of-range writes drop, out-of-range reads return zero
    for (int a = 0; a < 6; a++) d_write(4'(a), 8'(48 + a), 1'b0);
    chk("d_drop_idle", 64'(d_w_drop), 64'd0);
    d_write(4'd12, 8'hEE, 1'b1);
    chk("d_oor_drop", 64'(d_w_drop), 64'd1);
    chk("d_oor_wbank", 64'(d_wbank), 64'd0);
    chk("d_oor_r_valid", 64'(d_r_valid), 64'd0);
    d_write(4'd15, 8'hEE, 1'b0);
    chk("d_oor15_drop", 64'(d_w_drop), 64'd1);
    for (int a = 6; a < 12; a++) d_write(4'(a), 8'(48 + a), (a == 11));
    chk("d_fill_wbank", 64'(d_wbank), 64'd1);
    chk("d_fill_r_valid", 64'(d_r_valid), 64'd1);
    d_read(4'd13, 4'd11, 16'h3B00);
    d_read(4'd12, 4'd0, 16'h3000);

    // LANES 4: ignored release before any fill, then four distinct lanes
    f_r_release = 1'b1; f_r_en = 4'hF;
    tick();
    f_r_release = 1'b0; f_r_en = 4'h0;
    chk("f_ign_vld", 64'(f_r_data_vld), 64'd0);
    chk("f_ign_rbank", 64'(f_rbank), 64'd0);
    chk("f_ign_w_ready", 64'(f_w_ready), 64'd1);
    for (int a = 0; a < 16; a++) begin
      f_w_en = 1'b1; f_w_addr = 4'(a); f_w_data = 8'(a * 7 + 3); f_w_last = (a == 15);
      tick();
    end
    f_w_en = 1'b0; f_w_last = 1'b0;
    chk("f_r_valid", 64'(f_r_valid), 64'd1);
    f_read({4'd0, 4'd14, 4'd9, 4'd2}, 32'h0365_4211);
    f_read({4'd3, 4'd8, 4'd1, 4'd15}, 32'h183B_0A6C);

    // Asynchronous reset in the middle of a B1 fill
    m_write(4'd0, 8'h11, 1'b0, 1'b0);
    m_write(4'd1, 8'h22, 1'b0, 1'b0);
    m_w_en = 1'b1; m_w_addr = 4'd2; m_w_data = 8'h33;
    #3 reset = 1'b0;
    #1;
    chk("arst_r_data", 64'(m_r_data), 64'd0);
    chk("arst_r_vld", 64'(m_r_data_vld), 64'd0);
    chk("arst_wbank", 64'(m_wbank), 64'd0);
    chk("arst_rbank", 64'(m_rbank), 64'd0);
    chk("arst_f_r_data", 64'(f_r_data), 64'd0);
    m_w_en = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("arst_r_valid", 64'(m_r_valid), 64'd0);
    chk("arst_w_ready", 64'(m_w_ready), 64'd1);
    chk("arst_w_drop", 64'(m_w_drop), 64'd0);

    tick(); tick();
    chk("m_queue_drained", 64'(exp_m.size()), 64'd0);
    chk("d_queue_drained", 64'(exp_d.size()), 64'd0);
    chk("f_queue_drained", 64'(exp_f.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
